// File: rtl/arbiter_rr4_pkg.sv
// Shared types and sizes for the four-requester round-robin arbiter.
package arbiter_rr4_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 8;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/arbiter_rr4_prio_enc.sv
// 4-to-2 priority encoder: highest set index wins; zero flags an all-clear input.
module priority_encoder4X2
    import arbiter_rr4_pkg::*;
(
    input  logic [NUM_REQ-1:0] in,
    output logic [ID_W-1:0]    id,
    output logic               zero
);

    always_comb begin
        // NOTE: every output gets a default first so no path through this block infers a latch.
        id   = '0;
        zero = 1'b0;
        if (in[3])      id = 2'd3;
        else if (in[2]) id = 2'd2;
        else if (in[1]) id = 2'd1;
        else if (in[0]) id = 2'd0;
        else            zero = 1'b1;
    end

endmodule

// File: rtl/arbiter_rr4.sv
// Round-robin arbiter for four masters: grant held until done, request drop,
// or MAX_HOLD cycles, with one idle turnaround cycle between grants.
module arbiter_rr4
    import arbiter_rr4_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_valid,
    output logic               timeout
);

    function automatic logic [NUM_REQ-1:0] lower_mask(input logic [ID_W-1:0] idx);
        return (NUM_REQ'(1) << idx) - NUM_REQ'(1);
    endfunction

    arb_state_e         state_q, state_d;
    logic [ID_W-1:0]    last_id_q, last_id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] grant_d;
    logic [ID_W-1:0]    grant_id_d;
    logic               timeout_d;

    logic [NUM_REQ-1:0] masked;
    logic [ID_W-1:0]    masked_id, req_id, winner;
    logic               masked_zero, req_zero;
    logic               owner_req, hit_limit, release_now;

    assign masked = req & lower_mask(last_id_q);

    priority_encoder4X2 u_enc_masked (.in(masked), .id(masked_id), .zero(masked_zero));
    priority_encoder4X2 u_enc_req    (.in(req),    .id(req_id),    .zero(req_zero));

    // Prefer masters below the last winner; wrap to the full set when none ask.
    assign winner      = masked_zero ? req_id : masked_id;
    assign owner_req   = req[grant_id];
    assign hit_limit   = (cnt_q == CNT_W'(MAX_HOLD));
    assign release_now = done | ~owner_req | hit_limit;

    always_comb begin
        state_d    = state_q;
        last_id_d  = last_id_q;
        cnt_d      = cnt_q;
        grant_d    = grant;
        grant_id_d = grant_id;
        timeout_d  = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (!req_zero) begin
                    state_d    = ARB_BUSY;
                    grant_d    = NUM_REQ'(1) << winner;
                    grant_id_d = winner;
                    last_id_d  = winner;
                    cnt_d      = CNT_W'(1);
                end
            end
            ARB_BUSY: begin
                if (release_now) begin
                    state_d   = ARB_IDLE;
                    grant_d   = '0;
                    // Only a release caused by the hold limit alone is a timeout.
                    timeout_d = hit_limit & ~done & owner_req;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            last_id_q <= '0;
            cnt_q     <= '0;
            grant     <= '0;
            grant_id  <= '0;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_id_q <= last_id_d;
            cnt_q     <= cnt_d;
            grant     <= grant_d;
            grant_id  <= grant_id_d;
            timeout   <= timeout_d;
        end
    end

    assign grant_valid = |grant;

endmodule
